dsp_coef_load_ctrl: RTL and testbench

- Sequences coefficient loading into a chain of NUM_TAPS DSP slices.
- Each slice's B input stage is configured for two registers, with the B cascade (BCOUT to next slice's BCIN) taken from B1.
- Coefficients stream into the first slice and shift through the B1 registers (shadow set) using CEB1 pulses. A single CEB2 pulse then commits all B1 values into B2 (active set) at the same time, so taps update glitch-free while the multipliers keep running from B2.

---
 rtl/dsp_coef_load_ctrl_if.sv | 24 ++
 rtl/dsp_coef_load_ctrl.sv | 115 +++++++++++
 tb/tb_dsp_coef_load_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_coef_load_ctrl_if.sv
// Coefficient stream interface for dsp_coef_load_ctrl.
//   coef_data  : coefficient beat (width DATA_W, matches slice B port)
//   coef_valid : coef_data valid, driven by the coefficient source
//   coef_ready : controller accepts a beat this cycle
// Modports: master = coefficient source, slave = load controller.
interface dsp_coef_load_ctrl_if #(
    parameter int DATA_W = 18
);
    logic signed [DATA_W-1:0] coef_data;
    logic                     coef_valid;
    logic                     coef_ready;

    modport master (
        output coef_data,
        output coef_valid,
        input  coef_ready
    );

    modport slave (
        input  coef_data,
        input  coef_valid,
        output coef_ready
    );
endinterface

// File: rtl/dsp_coef_load_ctrl.sv
// Coefficient load sequencer for a chain of NUM_TAPS cascaded DSP slices.
// Beats are shifted through the B1 (shadow) registers of the chain with
// ceb1 pulses; one ceb2 pulse then copies every B1 into B2 (active set) at
// once, so all taps change in the same cycle while the multipliers run.
// Ports:
//   clk, RSTB      : clock, synchronous active-high reset
//   coef           : coefficient stream (slave side of dsp_coef_load_ctrl_if)
//   load_start     : begin a load (IDLE only)
//   abort          : cancel a load in SHIFT or FULL
//   auto_commit    : commit as soon as the shadow set is full
//   commit_req     : commit request, honoured only in FULL
//   preview_en     : in FULL, feed the multipliers from B1
//   b_out          : B input of slice 0
//   ceb1, ceb2     : broadcast clock enables for B1 / B2
//   inmode_b1      : broadcast INMODE[4] (1 = multiply from B1)
//   busy           : a load sequence is in progress
//   shadow_full    : shadow set loaded, waiting for commit
//   done           : one-cycle pulse together with the ceb2 commit pulse
module dsp_coef_load_ctrl #(
    parameter int NUM_TAPS = 4,
    parameter int DATA_W   = 18
) (
    input  logic                     clk,
    input  logic                     RSTB,
    dsp_coef_load_ctrl_if.slave      coef,
    input  logic                     load_start,
    input  logic                     abort,
    input  logic                     auto_commit,
    input  logic                     commit_req,
    input  logic                     preview_en,
    output logic signed [DATA_W-1:0] b_out,
    output logic                     ceb1,
    output logic                     ceb2,
    output logic                     inmode_b1,
    output logic                     busy,
    output logic                     shadow_full,
    output logic                     done
);

    localparam int CNT_W = $clog2(NUM_TAPS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_TAPS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic             ready;
    logic             hs;
    logic             start_go;
    logic             commit_go;

    assign ready       = (state == ST_SHIFT);
    assign coef.coef_ready = ready;

    // abort outranks a beat presented in the same cycle
    assign hs        = ready && coef.coef_valid && !abort;
    assign start_go  = (state == ST_IDLE) && load_start && !abort;
    assign commit_go = (state == ST_FULL) && !abort && (auto_commit || commit_req);

    assign busy        = (state != ST_IDLE);
    assign shadow_full = (state == ST_FULL);
    assign inmode_b1   = preview_en && (state == ST_FULL);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_go) state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (abort)
                    state_nxt = ST_IDLE;
                else if (hs && (beat_cnt == LAST_BEAT))
                    state_nxt = ST_FULL;
            end
            ST_FULL: begin
                if (abort)
                    state_nxt = ST_IDLE;
                else if (commit_go)
                    state_nxt = ST_COMMIT;
            end
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs: ceb1/b_out one cycle after the handshake, ceb2/done
    // one cycle after the FULL decision, so the final B1 shift always lands
    // at least one edge before B2 captures. SHIFT exits at NUM_TAPS beats,
    // so the counter never wraps.
    always_ff @(posedge clk) begin
        if (RSTB) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            b_out    <= '0;
            ceb1     <= 1'b0;
            ceb2     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            ceb1  <= hs;
            ceb2  <= commit_go;
            done  <= commit_go;
            if (hs) begin
                b_out    <= coef.coef_data;
                beat_cnt <= beat_cnt + 1'b1;
            end else if (start_go) begin
                beat_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dsp_coef_load_ctrl.sv
// Testbench for dsp_coef_load_ctrl: a NUM_TAPS=4 instance checked every
// cycle against a behavioural model plus a slice-chain model, and a
// NUM_TAPS=1 instance checked with hand-computed values.
module tb_dsp_coef_load_ctrl;

    localparam int N  = 4;
    localparam int DW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic RSTB;
    logic load_start, abort, auto_commit, commit_req, preview_en;
    logic [DW-1:0] b_out;
    logic ceb1, ceb2, inmode_b1, busy, shadow_full, done;

    logic ls1, ab1, ac1, cr1, pe1;
    logic [DW-1:0] b_out1;
    logic ceb1_1, ceb2_1, inmode1, busy1, full1, done1;

    dsp_coef_load_ctrl_if #(.DATA_W(DW)) cif ();
    dsp_coef_load_ctrl_if #(.DATA_W(DW)) cif1 ();

    dsp_coef_load_ctrl #(.NUM_TAPS(N), .DATA_W(DW)) dut (
        .clk(clk), .RSTB(RSTB), .coef(cif),
        .load_start(load_start), .abort(abort), .auto_commit(auto_commit),
        .commit_req(commit_req), .preview_en(preview_en),
        .b_out(b_out), .ceb1(ceb1), .ceb2(ceb2), .inmode_b1(inmode_b1),
        .busy(busy), .shadow_full(shadow_full), .done(done)
    );

    dsp_coef_load_ctrl #(.NUM_TAPS(1), .DATA_W(DW)) dut1 (
        .clk(clk), .RSTB(RSTB), .coef(cif1),
        .load_start(ls1), .abort(ab1), .auto_commit(ac1),
        .commit_req(cr1), .preview_en(pe1),
        .b_out(b_out1), .ceb1(ceb1_1), .ceb2(ceb2_1), .inmode_b1(inmode1),
        .busy(busy1), .shadow_full(full1), .done(done1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model. m_pos: -1 idle, 0..N-1 beats held in the shadow
    // chain while loading, N shadow full, N+1 commit cycle.
    int            m_pos  = -1;
    logic [DW-1:0] m_bout = '0;
    logic          m_ceb1 = 1'b0;
    logic          m_ceb2 = 1'b0;

    always @(posedge clk) begin
        if (RSTB) begin
            m_pos  <= -1;
            m_bout <= '0;
            m_ceb1 <= 1'b0;
            m_ceb2 <= 1'b0;
        end else begin
            m_ceb1 <= 1'b0;
            m_ceb2 <= 1'b0;
            if (m_pos == -1) begin
                if (load_start && !abort) m_pos <= 0;
            end else if (m_pos == N + 1) begin
                m_pos <= -1;
            end else if (abort) begin
                m_pos <= -1;
            end else if (m_pos < N) begin
                if (cif.coef_valid) begin
                    m_bout <= cif.coef_data;
                    m_ceb1 <= 1'b1;
                    m_pos  <= m_pos + 1;
                end
            end else if (auto_commit || commit_req) begin
                m_pos  <= N + 1;
                m_ceb2 <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("coef_ready", cif.coef_ready, (m_pos >= 0 && m_pos < N));
            check("b_out", b_out, m_bout);
            check("ceb1", ceb1, m_ceb1);
            check("ceb2", ceb2, m_ceb2);
            check("done", done, m_ceb2);
            check("busy", busy, (m_pos != -1));
            check("shadow_full", shadow_full, (m_pos == N));
            check("inmode_b1", inmode_b1, (preview_en && m_pos == N));
        end
    end

    // Slice chain driven by the DUT outputs: B1 shifts on ceb1, B2 loads on ceb2.
    logic [DW-1:0] b1 [N] = '{default: '0};
    logic [DW-1:0] b2 [N] = '{default: '0};
    int n_ceb1 = 0;
    int n_ceb2 = 0;

    always @(posedge clk) begin
        if (ceb1 === 1'b1) begin
            b1[0] <= b_out;
            for (int k = 1; k < N; k++) b1[k] <= b1[k-1];
        end
        if (ceb2 === 1'b1)
            for (int k = 0; k < N; k++) b2[k] <= b1[k];
    end

    always @(negedge clk) begin
        if (ceb1 === 1'b1) n_ceb1 <= n_ceb1 + 1;
        if (ceb2 === 1'b1) n_ceb2 <= n_ceb2 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_b2(input string tag, input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                            input logic [DW-1:0] s2, input logic [DW-1:0] s3);
        check({tag, "_b2_0"}, b2[0], s0);
        check({tag, "_b2_1"}, b2[1], s1);
        check({tag, "_b2_2"}, b2[2], s2);
        check({tag, "_b2_3"}, b2[3], s3);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d);
        cif.coef_valid = 1'b1;
        cif.coef_data  = d;
        tick();
        cif.coef_valid = 1'b0;
    endtask

    int c1, c2;
    logic [DW-1:0] stall_data [7];
    logic          stall_vld  [7];

    initial begin
        RSTB = 1'b1;
        load_start = 0; abort = 0; auto_commit = 0; commit_req = 0; preview_en = 0;
        cif.coef_valid = 0; cif.coef_data = '0;
        ls1 = 0; ab1 = 0; ac1 = 1; cr1 = 0; pe1 = 0;
        cif1.coef_valid = 0; cif1.coef_data = '0;
        tick(); tick(); tick();

        check("rst_busy", busy, 1'b0);
        check("rst_ceb1", ceb1, 1'b0);
        check("rst_ceb2", ceb2, 1'b0);
        check("rst_b_out", b_out, '0);
        check("rst_ready", cif.coef_ready, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        RSTB = 1'b0;
        chk_en = 1'b1;
        tick();

        // Basic load, auto commit
        auto_commit = 1'b1;
        c1 = n_ceb1; c2 = n_ceb2;
        start_load();
        beat(18'h00011); beat(18'h00022); beat(18'h00033);
        beat(18'h00044);
        check("basic_last_ceb1", ceb1, 1'b1);
        check("basic_last_bout", b_out, 18'h00044);
        tick();
        check("basic_ceb2", ceb2, 1'b1);
        check("basic_done", done, 1'b1);
        tick(); tick();
        check("basic_busy", busy, 1'b0);
        check("basic_n_ceb1", n_ceb1 - c1, 4);
        check("basic_n_ceb2", n_ceb2 - c2, 1);
        check_b2("basic", 18'h44, 18'h33, 18'h22, 18'h11);

        // Stalls: valid 1,0,0,1,1,0,1; data on gaps is garbage
        stall_vld  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        stall_data = '{18'h00011, 18'h3ABCD, 18'h3ABCD, 18'h00022, 18'h00033, 18'h3ABCD, 18'h00044};
        c1 = n_ceb1;
        start_load();
        for (int i = 0; i < 7; i++) begin
            cif.coef_valid = stall_vld[i];
            cif.coef_data  = stall_data[i];
            tick();
        end
        cif.coef_valid = 1'b0;
        tick(); tick(); tick();
        check("stall_n_ceb1", n_ceb1 - c1, 4);
        check_b2("stall", 18'h44, 18'h33, 18'h22, 18'h11);

        // Manual commit with preview
        auto_commit = 1'b0;
        preview_en  = 1'b1;
        c2 = n_ceb2;
        start_load();
        beat(18'h00101); beat(18'h00202); beat(18'h00303); beat(18'h00404);
        for (int i = 0; i < 10; i++) tick();
        check("man_full", shadow_full, 1'b1);
        check("man_inmode", inmode_b1, 1'b1);
        check("man_no_ceb2", n_ceb2 - c2, 0);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        check("man_ceb2", ceb2, 1'b1);
        check("man_done", done, 1'b1);
        check("man_inmode_off", inmode_b1, 1'b0);
        tick();
        check("man_idle", busy, 1'b0);
        preview_en = 1'b0;
        check_b2("man", 18'h404, 18'h303, 18'h202, 18'h101);

        // Abort after two beats, together with a valid beat
        auto_commit = 1'b1;
        c1 = n_ceb1; c2 = n_ceb2;
        start_load();
        beat(18'h00555); beat(18'h00666);
        abort = 1'b1;
        cif.coef_valid = 1'b1;
        cif.coef_data  = 18'h00777;
        tick();
        abort = 1'b0;
        cif.coef_valid = 1'b0;
        check("abort_idle", busy, 1'b0);
        check("abort_no_ceb1", ceb1, 1'b0);
        tick(); tick(); tick();
        check("abort_n_ceb1", n_ceb1 - c1, 2);
        check("abort_n_ceb2", n_ceb2 - c2, 0);
        check_b2("abort", 18'h404, 18'h303, 18'h202, 18'h101);

        // Reset while FULL with commit_req; IDLE inputs ignored
        auto_commit = 1'b0;
        c2 = n_ceb2;
        start_load();
        beat(18'h00AAA); beat(18'h00BBB); beat(18'h00CCC); beat(18'h00DDD);
        check("rstfull_full", shadow_full, 1'b1);
        RSTB = 1'b1;
        commit_req = 1'b1;
        tick();
        check("rstfull_ceb2", ceb2, 1'b0);
        check("rstfull_busy", busy, 1'b0);
        check("rstfull_bout", b_out, '0);
        load_start = 1'b1;
        cif.coef_valid = 1'b1;
        tick();
        RSTB = 1'b0;
        load_start = 1'b0;
        tick();
        check("rst_ls_ignored", busy, 1'b0);
        tick(); tick();
        commit_req = 1'b0;
        cif.coef_valid = 1'b0;
        check("idle_busy", busy, 1'b0);
        check("rstfull_n_ceb2", n_ceb2 - c2, 0);
        check_b2("rstfull", 18'h404, 18'h303, 18'h202, 18'h101);

        // load_start during SHIFT must not restart the beat count
        auto_commit = 1'b1;
        start_load();
        beat(18'h00001); beat(18'h00002);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        beat(18'h00003); beat(18'h00004);
        check("ls_shift_full", shadow_full, 1'b1);
        tick(); tick(); tick();
        check_b2("ls_shift", 18'h4, 18'h3, 18'h2, 18'h1);

        // NUM_TAPS=1 instance: single beat fills the chain
        ls1 = 1'b1;
        tick();
        ls1 = 1'b0;
        check("t1_ready", cif1.coef_ready, 1'b1);
        cif1.coef_valid = 1'b1;
        cif1.coef_data  = 18'h3FFFF;
        tick();
        cif1.coef_valid = 1'b0;
        check("t1_ceb1", ceb1_1, 1'b1);
        check("t1_bout", b_out1, 18'h3FFFF);
        check("t1_full", full1, 1'b1);
        check("t1_ceb2_early", ceb2_1, 1'b0);
        tick();
        check("t1_ceb2", ceb2_1, 1'b1);
        check("t1_done", done1, 1'b1);
        check("t1_ceb1_off", ceb1_1, 1'b0);
        tick();
        check("t1_idle", busy1, 1'b0);
        check("t1_ceb2_off", ceb2_1, 1'b0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
